// File: rtl/vga_mem_arbiter.sv
// Fixed-priority arbiter (VGA > IR refresh > CPU) for one synchronous-read memory port.
// Also runs the once-per-frame IR temperature refresh that commits eight words atomically.
module vga_mem_arbiter #(
   parameter logic [23:0] IR_BASE = 24'h002400
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_req,
   input  logic [23:0] vga_mem_addr,
   output logic [15:0] data_from_mem_to_vga,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [23:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_ack,
   input  logic        vs,
   output logic [23:0] mem_addr,
   output logic        mem_we,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic [15:0] temp_0_16,
   output logic [15:0] temp_1_16,
   output logic [15:0] temp_2_16,
   output logic [15:0] temp_3_16,
   output logic [15:0] temp_4_16,
   output logic [15:0] temp_5_16,
   output logic [15:0] temp_6_16,
   output logic [15:0] temp_7_16,
   output logic        ir_refresh_done
);

   typedef enum logic [1:0] {OwnNone, OwnVga, OwnIr, OwnCpu} owner_e;
   typedef enum logic [1:0] {StIdle, StFetch, StDrain} ir_state_e;

   ir_state_e         state_q, state_d;
   owner_e            owner_q, owner_d;
   logic [2:0]        idx_q, idx_d;
   logic [2:0]        slot_q, slot_d;
   logic              vs_q;
   logic [7:0][15:0]  shadow_q, shadow_d;
   logic [7:0][15:0]  temp_q, temp_d;
   logic [15:0]       vga_data_q, vga_data_d;
   logic [15:0]       cpu_rdata_q, cpu_rdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              done_q, done_d;
   logic              grant_vga, grant_ir, grant_cpu;

   // CPU stays blocked while its read is in flight and during its ack cycle.
   always_comb begin
      grant_vga = vga_req;
      grant_ir  = !vga_req && (state_q == StFetch);
      grant_cpu = !vga_req && !grant_ir && cpu_req && !cpu_ack_q && (owner_q != OwnCpu);
      mem_addr  = '0;
      owner_d   = OwnNone;
      if (grant_vga) begin
         mem_addr = vga_mem_addr;
         owner_d  = OwnVga;
      end else if (grant_ir) begin
         mem_addr = IR_BASE + {21'd0, idx_q};
         owner_d  = OwnIr;
      end else if (grant_cpu) begin
         mem_addr = cpu_addr;
         owner_d  = cpu_we ? OwnNone : OwnCpu;
      end
   end

   assign mem_we    = grant_cpu && cpu_we && !reset;
   assign mem_wdata = cpu_wdata;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      slot_d      = idx_q;
      shadow_d    = shadow_q;
      temp_d      = temp_q;
      done_d      = 1'b0;
      vga_data_d  = vga_data_q;
      cpu_rdata_d = cpu_rdata_q;
      cpu_ack_d   = grant_cpu && cpu_we;

      unique case (owner_q)
         OwnVga:  vga_data_d = mem_rdata;
         OwnIr:   shadow_d[slot_q] = mem_rdata;
         OwnCpu: begin
            cpu_rdata_d = mem_rdata;
            cpu_ack_d   = 1'b1;
         end
         default: ;
      endcase

      unique case (state_q)
         StIdle: begin
            if (vs_q && !vs) begin
               idx_d   = 3'd0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (grant_ir) begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StDrain;
            end
         end
         StDrain: begin
            // shadow_d already carries the last word arriving this cycle.
            temp_d  = shadow_d;
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         owner_q     <= OwnNone;
         idx_q       <= 3'd0;
         slot_q      <= 3'd0;
         vs_q        <= 1'b1;
         shadow_q    <= '0;
         temp_q      <= '0;
         vga_data_q  <= '0;
         cpu_rdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         idx_q       <= idx_d;
         slot_q      <= slot_d;
         vs_q        <= vs;
         shadow_q    <= shadow_d;
         temp_q      <= temp_d;
         vga_data_q  <= vga_data_d;
         cpu_rdata_q <= cpu_rdata_d;
         cpu_ack_q   <= cpu_ack_d;
         done_q      <= done_d;
      end
   end

   assign data_from_mem_to_vga = vga_data_q;
   assign cpu_rdata            = cpu_rdata_q;
   assign cpu_ack              = cpu_ack_q;
   assign ir_refresh_done      = done_q;
   assign temp_0_16            = temp_q[0];
   assign temp_1_16            = temp_q[1];
   assign temp_2_16            = temp_q[2];
   assign temp_3_16            = temp_q[3];
   assign temp_4_16            = temp_q[4];
   assign temp_5_16            = temp_q[5];
   assign temp_6_16            = temp_q[6];
   assign temp_7_16            = temp_q[7];

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed scenarios, then a randomized phase checked against a
// transaction-level model of priority, read latency and the refresh cycle count.
module tb_vga_mem_arbiter;

   localparam logic [23:0] IrBase = 24'h002400;

   logic        clk, reset, vga_req, cpu_req, cpu_we, cpu_ack, vs, mem_we, ir_refresh_done;
   logic [23:0] vga_mem_addr, cpu_addr, mem_addr;
   logic [15:0] data_from_mem_to_vga, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
   logic [15:0] temps [8];

   logic [15:0] mem     [0:16383];
   logic [15:0] ref_mem [0:16383];
   logic [15:0] cur_temp [8];
   logic        mem_init;
   int          checks, failures;

   vga_mem_arbiter #(.IR_BASE(IrBase)) dut (
      .clk                  (clk),
      .reset                (reset),
      .vga_req              (vga_req),
      .vga_mem_addr         (vga_mem_addr),
      .data_from_mem_to_vga (data_from_mem_to_vga),
      .cpu_req              (cpu_req),
      .cpu_we               (cpu_we),
      .cpu_addr             (cpu_addr),
      .cpu_wdata            (cpu_wdata),
      .cpu_rdata            (cpu_rdata),
      .cpu_ack              (cpu_ack),
      .vs                   (vs),
      .mem_addr             (mem_addr),
      .mem_we               (mem_we),
      .mem_wdata            (mem_wdata),
      .mem_rdata            (mem_rdata),
      .temp_0_16            (temps[0]),
      .temp_1_16            (temps[1]),
      .temp_2_16            (temps[2]),
      .temp_3_16            (temps[3]),
      .temp_4_16            (temps[4]),
      .temp_5_16            (temps[5]),
      .temp_6_16            (temps[6]),
      .temp_7_16            (temps[7]),
      .ir_refresh_done      (ir_refresh_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] init_val(input int i);
      if (i >= 'h2400 && i < 'h2408) return 16'h0100 + 16'(i - 'h2400);
      if (i == 'h10) return 16'hBEEF;
      return 16'(i * 40503) ^ 16'h5A5A;
   endfunction

   // Synchronous-read memory behind the port.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16384; i++) mem[i] <= init_val(i);
      end else begin
         if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
         mem_rdata <= mem[mem_addr[13:0]];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_xfer(input logic we, input logic [23:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      lat = 0; rd = '0;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (cpu_ack) begin
            lat = n;
            rd  = cpu_rdata;
            break;
         end
      end
      chk("cpu_ack_seen", 32'(lat != 0), 1);
      cpu_req = 1'b0;
      if (we) ref_mem[a[13:0]] = d;
   endtask

   // mode 0: plain, 1: VGA 1,1,0,0 load, 2: second vs edge during FETCH.
   task automatic run_refresh(input int mode);
      int free, done_at, dones;
      free = 0; done_at = -1; dones = 0;
      vga_mem_addr = 24'h10;
      for (int c = 0; c < 24; c++) begin
         vga_req = (mode == 1) && (((c + 1) % 4) < 2);
         vs      = (mode == 2) && (c == 2 || c == 3);
         #1;
         if (c >= 1 && !vga_req && free < 8) begin
            chk("ir_fetch_addr", mem_addr, IrBase + 24'(free));
            free++;
            if (free == 8) done_at = c + 2;
         end else if (vga_req) begin
            chk("vga_over_ir_addr", mem_addr, 24'h10);
         end else begin
            chk("no_grant_addr", mem_addr, 0);
         end
         dones += int'(ir_refresh_done);
         if (c == done_at) begin
            chk("refresh_done_pulse", ir_refresh_done, 1);
            for (int k = 0; k < 8; k++) begin
               chk($sformatf("temp%0d_commit", k), temps[k], ref_mem[13'h400 + k + 'h2000]);
               cur_temp[k] = ref_mem[IrBase[13:0] + 14'(k)];
            end
         end else if (done_at >= 0 && c == done_at - 1) begin
            for (int k = 0; k < 8; k++) chk($sformatf("temp%0d_no_partial", k), temps[k], cur_temp[k]);
         end
         @(posedge clk);
         #1;
      end
      chk("refresh_done_count", dones, 1);
      vga_req = 1'b0;
      vs = 1'b1;
      tick();
      tick();
   endtask

   initial begin
      logic [15:0] rd;
      int          lat;
      checks = 0; failures = 0;
      reset = 1'b1; mem_init = 1'b1; vs = 1'b1;
      vga_req = 1'b0; vga_mem_addr = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int i = 0; i < 16384; i++) ref_mem[i] = init_val(i);
      for (int k = 0; k < 8; k++) cur_temp[k] = '0;
      tick();
      tick();
      mem_init = 1'b0;

      // Reset state; a CPU write request during reset must not write.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h100; cpu_wdata = 16'hDEAD;
      #1;
      chk("we_during_reset", mem_we, 0);
      tick();
      chk("rst_vga_data", data_from_mem_to_vga, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_done", ir_refresh_done, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("rst_temp%0d", k), temps[k], 0);
      cpu_req = 1'b0; cpu_we = 1'b0;
      reset = 1'b0;
      tick();

      // VGA read with one-cycle memory latency.
      vga_req = 1'b1; vga_mem_addr = 24'h10;
      #1;
      chk("vga_addr_c0", mem_addr, 24'h10);
      tick();
      vga_req = 1'b0;
      #1;
      chk("idle_addr", mem_addr, 0);
      chk("vga_data_c1", data_from_mem_to_vga, 0);
      tick();
      chk("vga_data_c2", data_from_mem_to_vga, 16'hBEEF);
      tick();
      tick();
      chk("vga_data_hold", data_from_mem_to_vga, 16'hBEEF);

      // CPU write colliding with VGA.
      vga_req = 1'b1; vga_mem_addr = 24'h20;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h100; cpu_wdata = 16'h1234;
      #1;
      chk("collide_we_c0", mem_we, 0);
      chk("collide_addr_c0", mem_addr, 24'h20);
      tick();
      vga_req = 1'b0;
      #1;
      chk("collide_we_c1", mem_we, 1);
      chk("collide_addr_c1", mem_addr, 24'h100);
      chk("collide_ack_c1", cpu_ack, 0);
      tick();
      chk("collide_ack_c2", cpu_ack, 1);
      chk("collide_no_regrant", mem_we, 0);
      chk("collide_vga_data", data_from_mem_to_vga, init_val('h20));
      cpu_req = 1'b0;
      tick();
      chk("collide_ack_c3", cpu_ack, 0);
      ref_mem['h100] = 16'h1234;
      cpu_xfer(1'b0, 24'h100, 16'h0, rd, lat);
      chk("cpu_read_back", rd, 16'h1234);
      chk("cpu_read_latency", lat, 2);
      tick();

      // IR refresh: plain, under VGA load, then with a second edge during FETCH.
      run_refresh(0);
      for (int k = 0; k < 8; k++) cpu_xfer(1'b1, IrBase + 24'(k), 16'h0200 + 16'(k), rd, lat);
      tick();
      run_refresh(1);
      for (int k = 0; k < 8; k++) cpu_xfer(1'b1, IrBase + 24'(k), 16'h0300 + 16'(k), rd, lat);
      tick();
      run_refresh(2);

      // Reset while idx = 4, with a CPU read pending behind the IR engine.
      for (int c = 0; c < 6; c++) begin
         vs = 1'b0;
         cpu_req = (c >= 3); cpu_we = 1'b0; cpu_addr = 24'h100;
         reset = (c == 5);
         tick();
      end
      reset = 1'b0; cpu_req = 1'b0; vs = 1'b1;
      #1;
      chk("post_reset_idle_addr", mem_addr, 0);
      for (int k = 0; k < 8; k++) chk($sformatf("post_reset_temp%0d", k), temps[k], 0);
      for (int n = 0; n < 3; n++) begin
         chk("post_reset_no_ack", cpu_ack, 0);
         chk("post_reset_no_done", ir_refresh_done, 0);
         tick();
      end
      for (int k = 0; k < 8; k++) cur_temp[k] = '0;
      run_refresh(0);

      // Randomized phase against a transaction-level model.
      begin
         int          busy, left, done_at, cpu_wait;
         logic        vs_prev, p1_v, p2_v, vga_known, cpu_busy, cur_we;
         logic [15:0] p1_d, p2_d, exp_vga, cur_d;
         logic [23:0] cur_a;
         busy = 0; left = 0; done_at = -1; cpu_wait = 0;
         vs_prev = 1'b1; p1_v = 1'b0; p2_v = 1'b0; vga_known = 1'b0; cpu_busy = 1'b0;
         p1_d = '0; p2_d = '0; exp_vga = '0; cur_we = 1'b0; cur_d = '0; cur_a = '0;
         for (int c = 0; c < 600; c++) begin
            if (p2_v) begin
               exp_vga   = p2_d;
               vga_known = 1'b1;
            end
            if (vga_known) chk("rnd_vga_data", data_from_mem_to_vga, exp_vga);
            chk("rnd_done", ir_refresh_done, 32'(c == done_at));
            if (c == done_at) begin
               busy = 0;
               for (int k = 0; k < 8; k++)
                  chk($sformatf("rnd_temp%0d", k), temps[k], ref_mem[IrBase[13:0] + 14'(k)]);
            end
            if (cpu_busy && cpu_ack) begin
               if (!cur_we) chk("rnd_cpu_rdata", cpu_rdata, ref_mem[cur_a[13:0]]);
               else ref_mem[cur_a[13:0]] = cur_d;
               cpu_busy = 1'b0;
               cpu_req  = 1'b0;
            end else if (cpu_busy) begin
               cpu_wait++;
               if (cpu_wait > 60) begin
                  chk("rnd_cpu_wait_bound", 32'(cpu_wait), 60);
                  cpu_busy = 1'b0;
                  cpu_req  = 1'b0;
               end
            end else begin
               chk("rnd_cpu_spurious_ack", cpu_ack, 0);
               if ($urandom_range(0, 3) == 0) begin
                  cpu_busy = 1'b1; cpu_wait = 0;
                  cur_we   = 1'($urandom_range(0, 1));
                  cur_a    = 24'h100 + 24'($urandom_range(0, 15));
                  cur_d    = 16'($urandom);
                  cpu_req  = 1'b1; cpu_we = cur_we; cpu_addr = cur_a; cpu_wdata = cur_d;
               end
            end
            vga_req      = ($urandom_range(0, 2) == 0);
            vga_mem_addr = 24'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) vs = ~vs;
            #1;
            if (busy == 0 && vs_prev && !vs) begin
               busy = 1;
               left = 8;
               chk("rnd_edge_cycle_addr", mem_addr, vga_req ? vga_mem_addr : mem_addr);
            end else if (vga_req) begin
               chk("rnd_vga_addr", mem_addr, vga_mem_addr);
            end else if (busy != 0 && left > 0) begin
               chk("rnd_ir_addr", mem_addr, IrBase + 24'(8 - left));
               left--;
               if (left == 0) done_at = c + 2;
            end
            p2_v = p1_v; p2_d = p1_d;
            p1_v = vga_req; p1_d = ref_mem[vga_mem_addr[13:0]];
            vs_prev = vs;
            @(posedge clk);
            #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
